// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//   Byte FIFO plus sequencer in front of the UART transmitter. Bytes written
//   from the bus side are buffered, then handed to the transmitter one at a
//   time. The feeder waits for the transmitter's done pulse before it issues
//   the next byte.
//
// Handshake: a byte is handed over by a single-cycle tx_enable pulse with
//   tx_data valid on that cycle. tx_data then stays stable until the next
//   pulse. The transmitter acknowledges the start by raising tx_active, and
//   signals the end of the byte with a one-cycle tx_done. A write on wr_en is
//   taken on the same edge it is sampled unless the buffer is full. A full
//   buffer can still take a write on the edge that pops a byte.
//
// Ports:
//   clock, reset         system clock, asynchronous active-high reset
//   wr_data, wr_en       byte to enqueue and its enqueue request
//   full, empty, count   buffer occupancy (count runs 0..DEPTH)
//   overflow             one-cycle pulse when a write is rejected
//   tx_data, tx_enable   byte and start pulse to the transmitter
//   tx_active, tx_done   transmitter busy flag and completion pulse
//   busy                 feeder has work in flight or bytes buffered
//   state_dbg            current sequencer state (IDLE=0, ISSUE=1, WAIT_DONE=2)
module uart_tx_feeder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [7:0]        tx_data,
  output logic              tx_enable,
  input  logic              tx_active,
  input  logic              tx_done,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              pop;
  logic              wr_accept;

  // Flags come from the registered count, so they never glitch on inputs.
  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign busy      = (state != IDLE) || !empty;
  assign state_dbg = state;

  // A byte is popped only when the sequencer starts a new transfer. That pop
  // frees one slot on the same edge, so a write at full is still accepted.
  assign pop       = (state == IDLE) && !empty;
  assign wr_accept = wr_en && (!full || pop);

  // Storage is not reset; stale bytes are unreachable once the pointers clear.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      tx_data   <= 8'h00;
      tx_enable <= 1'b0;
      state     <= IDLE;
    end else begin
      overflow <= wr_en && !wr_accept;

      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end

      case ({wr_accept, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          tx_enable <= 1'b0;
          if (pop) begin
            tx_data   <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + PTR_ONE;
            tx_enable <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // The start pulse is never repeated; wait here for the transmitter
          // to acknowledge, however long that takes.
          tx_enable <= 1'b0;
          if (tx_active) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          tx_enable <= 1'b0;
          if (tx_done) begin
            state <= IDLE;
          end
        end
        default: begin
          tx_enable <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [7:0]      wr_data = 8'h00;
  logic            wr_en   = 1'b0;
  logic            full, empty, overflow, tx_enable, busy;
  logic [ADDR_W:0] count;
  logic [7:0]      tx_data;
  logic            tx_active, tx_done;
  logic [1:0]      state_dbg;

  uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .tx_data   (tx_data),
    .tx_enable (tx_enable),
    .tx_active (tx_active),
    .tx_done   (tx_done),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_err    = 0;
  int n_enable = 0;
  int max_cnt  = 0;
  logic [7:0] last_byte = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transmitter stand-in ----------------
  // Latches a start pulse, raises tx_active for frame_len cycles, then gives
  // a one-cycle done. While stall is set it never acknowledges.
  logic x_active = 1'b0;
  logic x_done   = 1'b0;
  logic pending  = 1'b0;
  logic inj_done = 1'b0;
  logic stall    = 1'b0;
  int   x_cnt    = 0;
  int   frame_len = 40;

  assign tx_active = x_active;
  assign tx_done   = x_done | inj_done;

  always @(negedge clock) begin
    if (reset) begin
      x_active = 1'b0;
      x_done   = 1'b0;
      x_cnt    = 0;
      pending  = 1'b0;
    end else begin
      x_done = 1'b0;
      if (tx_enable) pending = 1'b1;
      if (x_cnt > 0) begin
        x_cnt--;
        if (x_cnt == 0) begin
          x_active = 1'b0;
          x_done   = 1'b1;
        end
      end else if (pending && !stall) begin
        pending  = 1'b0;
        x_active = 1'b1;
        x_cnt    = frame_len;
      end
    end
  end

  // ---------------- reference model ----------------
  // Feeder seen as: a queue of waiting bytes plus a transfer phase
  // (0 = free to start, 1 = started but not acknowledged, 2 = awaiting done).
  logic [7:0] m_buf[$];
  logic [7:0] exp_q[$];
  int         m_phase     = 0;
  logic       m_overflow  = 1'b0;
  logic       m_tx_enable = 1'b0;
  logic [7:0] m_tx_data   = 8'h00;

  always @(posedge clock) begin
    if (reset) begin
      m_buf.delete();
      exp_q.delete();
      m_phase     = 0;
      m_overflow  = 1'b0;
      m_tx_enable = 1'b0;
      m_tx_data   = 8'h00;
    end else begin
      logic do_pop, acc;
      do_pop      = (m_phase == 0) && (m_buf.size() > 0);
      acc         = wr_en && ((m_buf.size() < DEPTH) || do_pop);
      m_overflow  = wr_en && !acc;
      m_tx_enable = do_pop;
      if (do_pop) begin
        m_tx_data = m_buf.pop_front();
        m_phase   = 1;
      end else if (m_phase == 1 && tx_active) begin
        m_phase = 2;
      end else if (m_phase == 2 && tx_done) begin
        m_phase = 0;
      end
      if (acc) begin
        m_buf.push_back(wr_data);
        exp_q.push_back(wr_data);
      end
    end
  end

  // ---------------- per-cycle output check ----------------
  always @(negedge clock) begin
    if (!reset) begin
      chk("count",     int'(count),     m_buf.size());
      chk("full",      int'(full),      int'(m_buf.size() == DEPTH));
      chk("empty",     int'(empty),     int'(m_buf.size() == 0));
      chk("overflow",  int'(overflow),  int'(m_overflow));
      chk("tx_enable", int'(tx_enable), int'(m_tx_enable));
      chk("tx_data",   int'(tx_data),   int'(m_tx_data));
      chk("busy",      int'(busy),      int'(m_phase != 0 || m_buf.size() != 0));
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (!reset && tx_enable) begin
      n_enable++;
      if (exp_q.size() == 0) begin
        chk("tx_unexpected", 1, 0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("tx_byte", int'(tx_data), int'(e));
      end
      last_byte = tx_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle_drive(input logic en, input logic [7:0] d);
    @(negedge clock);
    wr_en   = en;
    wr_data = d;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    bit done = 1'b0;
    for (int n = 0; n < max_cyc && !done; n++) begin
      @(negedge clock);
      if (m_phase == 0 && m_buf.size() == 0 && !x_active && !x_done && !pending)
        done = 1'b1;
    end
    if (!done) chk(name, 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    bit found;

    // Reset values
    @(negedge clock);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_tx_enable", int'(tx_enable), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overflow", int'(overflow), 0);
    @(negedge clock);
    reset = 1'b0;

    // Single byte: write at edge k, enable visible after edge k+1
    frame_len = 40;
    cycle_drive(1'b1, 8'hA5);
    cycle_drive(1'b0, 8'h00);
    chk("single_count_k", int'(count), 1);
    chk("single_en_k", int'(tx_enable), 0);
    @(negedge clock);
    chk("single_en_k1", int'(tx_enable), 1);
    chk("single_data", int'(tx_data), 8'hA5);
    @(negedge clock);
    chk("single_en_pulse", int'(tx_enable), 0);
    chk("single_data_hold", int'(tx_data), 8'hA5);
    wait_idle(200, "single_timeout");
    chk("single_busy_low", int'(busy), 0);

    // Burst ordering
    frame_len = 8;
    max_cnt = 0;
    base = n_enable;
    for (int i = 1; i <= 5; i++) cycle_drive(1'b1, 8'(i));
    cycle_drive(1'b0, 8'h00);
    wait_idle(300, "burst_timeout");
    chk("burst_peak", max_cnt, 4);
    chk("burst_pulses", n_enable - base, 5);
    chk("burst_last", int'(last_byte), 5);

    // Full / overflow with transmitter stalled
    stall = 1'b1;
    frame_len = 6;
    for (int i = 0; i < 17; i++) cycle_drive(1'b1, 8'(8'h40 + i));
    cycle_drive(1'b0, 8'h00);
    chk("full_count", int'(count), 16);
    chk("full_flag", int'(full), 1);
    chk("full_no_ovf", int'(overflow), 0);
    cycle_drive(1'b1, 8'h99);
    cycle_drive(1'b0, 8'h00);
    chk("ovf_pulse", int'(overflow), 1);
    chk("ovf_count", int'(count), 16);
    @(negedge clock);
    chk("ovf_one_cycle", int'(overflow), 0);

    // Simultaneous push/pop at full
    stall = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clock);
      if (m_phase == 0) found = 1'b1;
    end
    if (!found) chk("sim_timeout", 0, 1);
    wr_en = 1'b1;
    wr_data = 8'h3C;
    cycle_drive(1'b0, 8'h00);
    chk("sim_no_ovf", int'(overflow), 0);
    chk("sim_count", int'(count), 16);
    chk("sim_enable", int'(tx_enable), 1);
    wait_idle(400, "sim_drain_timeout");
    chk("sim_last_3c", int'(last_byte), 8'h3C);

    // Wrap-around
    frame_len = 2;
    base = n_enable;
    for (int i = 0; i < 40; i++) begin
      while (m_buf.size() >= 12) cycle_drive(1'b0, 8'h00);
      cycle_drive(1'b1, 8'(i));
      if ($urandom_range(0, 1) == 1) cycle_drive(1'b0, 8'h00);
    end
    cycle_drive(1'b0, 8'h00);
    wait_idle(600, "wrap_timeout");
    chk("wrap_pulses", n_enable - base, 40);
    chk("wrap_empty", int'(empty), 1);
    chk("wrap_last", int'(last_byte), 8'h27);

    // Randomized traffic including stray done pulses outside WAIT_DONE
    for (int c = 0; c < 1500; c++) begin
      @(negedge clock);
      wr_en     = ($urandom_range(0, 2) == 0);
      wr_data   = 8'($urandom_range(0, 255));
      inj_done  = (m_phase != 2) && ($urandom_range(0, 7) == 0);
      frame_len = $urandom_range(1, 5);
      if ($urandom_range(0, 99) == 0) stall = !stall;
    end
    @(negedge clock);
    wr_en = 1'b0;
    inj_done = 1'b0;
    stall = 1'b0;
    wait_idle(1000, "rand_timeout");
    chk("rand_drained", exp_q.size(), 0);

    // Reset during WAIT_DONE with five bytes buffered
    frame_len = 40;
    for (int i = 0; i < 6; i++) cycle_drive(1'b1, 8'(8'hC0 + i));
    cycle_drive(1'b0, 8'h00);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      if (m_phase == 2 && m_buf.size() == 5) found = 1'b1;
      else @(negedge clock);
    end
    if (!found) chk("midrst_timeout", 0, 1);
    chk("midrst_state", int'(state_dbg), 2);
    chk("midrst_count_before", int'(count), 5);
    reset = 1'b1;
    #1;
    chk("midrst_empty", int'(empty), 1);
    chk("midrst_count", int'(count), 0);
    chk("midrst_tx_enable", int'(tx_enable), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_state_idle", int'(state_dbg), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    base = n_enable;
    repeat (20) @(negedge clock);
    chk("midrst_quiet", n_enable - base, 0);
    cycle_drive(1'b1, 8'h5A);
    cycle_drive(1'b0, 8'h00);
    wait_idle(200, "post_rst_timeout");
    chk("post_rst_pulse", n_enable - base, 1);
    chk("post_rst_byte", int'(last_byte), 8'h5A);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte buffer and sequencer directly upstream of the UART transmitter.
- Accepts bytes from the bus/arbiter side into a FIFO. Presents them one at a time on the transmitter's writedata/enable handshake, and waits for the transmitter's done pulse before issuing the next byte.
- Decouples bursty bus writes from the slow serial bit rate.

Parameters:
- DEPTH, 16, FIFO depth in bytes; must be a power of two, at least 2.
- ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
- clock  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- wr_data  in  8  byte to enqueue
- wr_en  in  1  enqueue request, sampled each rising edge
- full  out  1  high when count == DEPTH
- empty  out  1  high when count == 0
- count  out  ADDR_W+1  bytes currently buffered (0..DEPTH)
- overflow  out  1  one-cycle pulse when a write is rejected
- tx_data  out  8  byte to the transmitter's writedata
- tx_enable  out  1  one-cycle start pulse to the transmitter's enable
- tx_active  in  1  transmitter busy flag
- tx_done  in  1  transmitter one-cycle completion pulse
- busy  out  1  high whenever the state is not IDLE or count != 0

Behaviour:
- Reset (async): all pointers and count cleared. full=0, empty=1, overflow=0, tx_data=0, tx_enable=0, busy=0, state=IDLE. FIFO storage is not cleared.
- A reset asserted mid-transfer discards all buffered bytes. The transmitter shares the same reset line and is not otherwise notified.
- All outputs are registered or derived from registered count/state.
- Write acceptance:
  - A write is accepted when wr_en=1 and (full=0 or a pop occurs in the same cycle).
  - An accepted write stores wr_data at wr_ptr, and wr_ptr increments modulo DEPTH (natural wrap).
  - A rejected write pulses overflow for exactly one cycle. FIFO contents, pointers and count are unchanged.
- Pop: happens only on the IDLE->ISSUE transition. Reads mem[rd_ptr] into tx_data, and rd_ptr increments modulo DEPTH.
- count: +1 on accepted write without pop, -1 on pop without write, unchanged when both occur or neither.
- State machine:
  - IDLE: tx_enable=0. If count != 0: pop, tx_data<=byte, tx_enable<=1, go to ISSUE. Otherwise stay.
  - ISSUE: tx_enable<=0, held low from here on. If tx_active=1, go to WAIT_DONE. Otherwise stay; the pulse is not re-issued.
  - WAIT_DONE: if tx_done=1, go to IDLE. Otherwise stay.
- tx_data is held stable from the pop edge until the next pop.
- Latency:
  - A write sampled at edge k into an empty, IDLE feeder gives tx_enable=1 after edge k+1 (count=1 after edge k; pop at edge k+1).
  - Inter-byte gap: the edge sampling tx_done=1 returns to IDLE; the next tx_enable rises one edge later.
- tx_done while in IDLE or ISSUE is ignored; there is no spurious state change.
- Bytes leave in strict FIFO order across pointer wrap.
- Simultaneous write and pop with count=DEPTH: write accepted, count stays DEPTH, no overflow.
- Simultaneous write and pop with count=1 in IDLE: the popped byte is the older one, and count stays 1.
- Pointer/count arithmetic is unsigned. count never exceeds DEPTH and never underflows.

Test Plan:
- Single byte: reset, write 0xA5 once at edge k -> tx_enable high exactly one cycle after edge k+1 with tx_data=0xA5. Paired transmitter (bit period 4 clocks) shifts out 0, 1,0,1,0,0,1,0,1, 1 LSB-first. busy falls after tx_done.
- Burst ordering: write 0x01..0x05 on five consecutive cycles -> count peaks at 4 (one popped immediately). Transmitter emits 0x01,0x02,0x03,0x04,0x05 in order. Exactly five tx_enable pulses, each following the previous tx_done.
- Full/overflow: with tx_active held 0 (stalls in ISSUE), write 17 bytes -> 1 popped, count=16, full=1. The 18th write pulses overflow once, and count stays 16.
- Simultaneous push/pop at full: count=16, release the transmitter so the next pop coincides with wr_en=1 (0x3C) -> no overflow, count stays 16, 0x3C emitted last.
- Wrap-around: push/pop 40 bytes (0x00..0x27) through DEPTH=16 -> output sequence identical, pointers wrap twice, empty=1 at end.
- Reset mid-operation: assert reset during WAIT_DONE with count=5 -> outputs immediately at reset values (empty=1, count=0, tx_enable=0). No further tx_enable until a new write.
